// File: rtl/pipe_stage_reg.sv
// Pipeline stage register for a PC/instruction pair with valid/ready handshake,
// flush-to-bubble, optional two-entry skid buffer and saturating perf counters.
module pipe_stage_reg #(
  parameter int                 PC_W     = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h00000013),
  parameter bit                 SKID     = 1'b1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              flush,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_reg;
  logic [PC_W-1:0]   main_pc_reg;
  logic [INST_W-1:0] main_inst_reg;
  logic              skid_valid_reg;
  logic [PC_W-1:0]   skid_pc_reg;
  logic [INST_W-1:0] skid_inst_reg;

  logic accept;
  logic send;
  logic main_load;

  assign send      = main_valid_reg & out_ready;
  assign accept    = in_valid & in_ready;
  assign main_load = !main_valid_reg | send;

  generate
    if (SKID) begin : g_skid
      // The skid only fills when main is held; in_ready comes straight off a flop.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          skid_valid_reg <= 1'b0;
          skid_pc_reg    <= '0;
          skid_inst_reg  <= '0;
        end else if (flush || main_load) begin
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          skid_valid_reg <= 1'b1;
          skid_pc_reg    <= in_pc;
          skid_inst_reg  <= in_inst;
        end
      end
      assign in_ready = !skid_valid_reg;
    end else begin : g_noskid
      assign skid_valid_reg = 1'b0;
      assign skid_pc_reg    = '0;
      assign skid_inst_reg  = '0;
      assign in_ready       = !main_valid_reg | out_ready;
    end
  endgenerate

  // An empty main register always carries pc=0 / NOP so the outputs need no muxing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_reg <= 1'b0;
      main_pc_reg    <= '0;
      main_inst_reg  <= NOP_INST;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      main_pc_reg    <= '0;
      main_inst_reg  <= NOP_INST;
    end else if (main_load) begin
      if (skid_valid_reg) begin
        main_valid_reg <= 1'b1;
        main_pc_reg    <= skid_pc_reg;
        main_inst_reg  <= skid_inst_reg;
      end else if (accept) begin
        main_valid_reg <= 1'b1;
        main_pc_reg    <= in_pc;
        main_inst_reg  <= in_inst;
      end else begin
        main_valid_reg <= 1'b0;
        main_pc_reg    <= '0;
        main_inst_reg  <= NOP_INST;
      end
    end
  end

  assign out_valid = main_valid_reg;
  assign out_pc    = main_pc_reg;
  assign out_inst  = main_inst_reg;

  // Counter order: 0 = stall, 1 = flush, 2 = bubble.
  logic [2:0] cnt_inc;
  assign cnt_inc = {!main_valid_reg & !flush, flush, main_valid_reg & !out_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_reg <= '0;
        end else if (cnt_clear) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != '1)) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt  = g_cnt[0].count_reg;
  assign flush_cnt  = g_cnt[1].count_reg;
  assign bubble_cnt = g_cnt[2].count_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: skid build with 4-bit counters plus a
// no-skid build, each with an in-order scoreboard on its output handshake.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Skid build (SKID=1, CNT_W=4)
  logic        in_valid, in_ready, out_valid, out_ready, flush, cnt_clear;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [3:0]  stall_cnt, flush_cnt, bubble_cnt;

  // No-skid build (SKID=0, CNT_W=16)
  logic        in_valid0, in_ready0, out_valid0, out_ready0, flush0, cnt_clear0;
  logic [31:0] in_pc0, in_inst0, out_pc0, out_inst0;
  logic [15:0] stall_cnt0, flush_cnt0, bubble_cnt0;

  pipe_stage_reg #(.PC_W(32), .INST_W(32), .SKID(1'b1), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .flush(flush), .cnt_clear(cnt_clear),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.PC_W(32), .INST_W(32), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_pc(in_pc0), .in_inst(in_inst0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_pc(out_pc0), .out_inst(out_inst0),
    .flush(flush0), .cnt_clear(cnt_clear0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0), .bubble_cnt(bubble_cnt0)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hABCD0000;
  endfunction

  // Scoreboards: push on accept, pop and compare on send; flush/reset empty them.
  logic [63:0] sb_q[$];
  logic [63:0] sb_q0[$];

  always @(negedge clk) begin
    logic [63:0] exp;
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (!out_valid) begin
        checks++;
        if (out_pc !== 32'h0 || out_inst !== NOP) begin
          errors++;
          $display("FAIL empty_payload: got pc=%h inst=%h expected pc=0 inst=%h", out_pc, out_inst, NOP);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h with no entry expected", out_pc);
        end else begin
          exp = sb_q.pop_front();
          if ({out_pc, out_inst} !== exp) begin
            errors++;
            $display("FAIL sb_order: got pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, exp[63:32], exp[31:0]);
          end else begin
            $display("send pc=%h inst=%h", out_pc, out_inst);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({in_pc, in_inst});
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp;
    if (!reset_n) begin
      sb_q0.delete();
    end else begin
      if (out_valid0 && out_ready0) begin
        checks++;
        if (sb_q0.size() == 0) begin
          errors++;
          $display("FAIL sb0_unexpected: got pc=%h with no entry expected", out_pc0);
        end else begin
          exp = sb_q0.pop_front();
          if ({out_pc0, out_inst0} !== exp) begin
            errors++;
            $display("FAIL sb0_order: got pc=%h inst=%h expected pc=%h inst=%h", out_pc0, out_inst0, exp[63:32], exp[31:0]);
          end else begin
            $display("send0 pc=%h inst=%h", out_pc0, out_inst0);
          end
        end
      end
      if (flush0) sb_q0.delete();
      else if (in_valid0 && in_ready0) sb_q0.push_back({in_pc0, in_inst0});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
  endtask

  task automatic drive0(input logic v, input logic [31:0] pc);
    in_valid0 = v;
    in_pc0    = pc;
    in_inst0  = inst_of(pc);
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", out_inst, NOP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if ({stall_cnt, flush_cnt, bubble_cnt} !== 12'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", {stall_cnt, flush_cnt, bubble_cnt}); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    clear_counters();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i) || out_inst !== inst_of(32'h100 + 32'(4 * i))) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, 32'h100 + 32'(4 * i));
      end
    end
    drive(1'b0, 32'h0);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_stall();
    clear_counters();
    out_ready = 1'b0;
    drive(1'b1, 32'h200);
    step();
    drive(1'b1, 32'h204);
    step();
    drive(1'b0, 32'h0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    step(2);
    checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL stall_hold: got %h expected 200", out_pc); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h204 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got pc=%h rdy=%b expected pc=204 rdy=1", out_pc, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_drain: got v=%b cnt=%0d expected v=0 cnt=3", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    clear_counters();
    out_ready = 1'b0;
    drive(1'b1, 32'h300);
    step();
    drive(1'b1, 32'h304);
    step();
    drive(1'b1, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== NOP) begin errors++; $display("FAIL flush_out: got v=%b pc=%h inst=%h expected v=0 pc=0 inst=%h", out_valid, out_pc, out_inst, NOP); end
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin errors++; $display("FAIL flush_cnts: got f=%0d s=%0d expected f=1 s=2", flush_cnt, stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_skid: got in_ready=%b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || bubble_cnt !== 4'd2) begin errors++; $display("FAIL flush_after: got v=%b bub=%0d expected v=0 bub=2", out_valid, bubble_cnt); end
    drive(1'b1, 32'h30C);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    checks++; if (out_valid !== 1'b0 || flush_cnt !== 4'd2) begin errors++; $display("FAIL flush_accept: got v=%b f=%0d expected v=0 f=2", out_valid, flush_cnt); end
    out_ready = 1'b1;
    drive(1'b1, 32'h310);
    step();
    drive(1'b0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || flush_cnt !== 4'd3) begin errors++; $display("FAIL flush_send: got v=%b f=%0d expected v=0 f=3", out_valid, flush_cnt); end
  endtask

  task automatic test_idle_counters();
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'(i % 2);
      step();
      checks++;
      if (out_valid !== 1'b0 || out_inst !== NOP) begin errors++; $display("FAIL idle_%0d: got v=%b inst=%h expected v=0 inst=%h", i, out_valid, out_inst, NOP); end
    end
    checks++; if (bubble_cnt !== 4'd5) begin errors++; $display("FAIL idle_bubble: got %0d expected 5", bubble_cnt); end
    clear_counters();
    checks++; if ({stall_cnt, flush_cnt, bubble_cnt} !== 12'h0) begin errors++; $display("FAIL cnt_clear: got %h expected 0", {stall_cnt, flush_cnt, bubble_cnt}); end
  endtask

  task automatic test_async_reset();
    clear_counters();
    out_ready = 1'b0;
    drive(1'b1, 32'h400);
    step();
    drive(1'b1, 32'h404);
    step();
    drive(1'b0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL areset_out: got v=%b pc=%h expected v=0 pc=0", out_valid, out_pc); end
    checks++; if (in_ready !== 1'b1 || stall_cnt !== 4'd0) begin errors++; $display("FAIL areset_state: got rdy=%b s=%0d expected rdy=1 s=0", in_ready, stall_cnt); end
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h500 + 32'(4 * i)) begin errors++; $display("FAIL areset_stream_%0d: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, 32'h500 + 32'(4 * i)); end
    end
    drive(1'b0, 32'h0);
    step();
  endtask

  task automatic test_saturate();
    clear_counters();
    out_ready = 1'b0;
    drive(1'b1, 32'h600);
    step();
    drive(1'b0, 32'h0);
    step(20);
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL saturate: got %0d expected 15", stall_cnt); end
    checks++; if (out_pc !== 32'h600) begin errors++; $display("FAIL saturate_hold: got %h expected 600", out_pc); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 4'd15) begin errors++; $display("FAIL saturate_drain: got v=%b s=%0d expected v=0 s=15", out_valid, stall_cnt); end
  endtask

  task automatic test_noskid();
    cnt_clear0 = 1'b1;
    step();
    cnt_clear0 = 1'b0;
    out_ready0 = 1'b0;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL ns_empty_ready: got %b expected 1", in_ready0); end
    drive0(1'b1, 32'h700);
    step();
    checks++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin errors++; $display("FAIL ns_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid0, in_ready0); end
    out_ready0 = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL ns_comb_ready_hi: got %b expected 1", in_ready0); end
    out_ready0 = 1'b0;
    #1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL ns_comb_ready_lo: got %b expected 0", in_ready0); end
    drive0(1'b1, 32'h704);
    step(3);
    checks++; if (stall_cnt0 !== 16'd3 || out_pc0 !== 32'h700) begin errors++; $display("FAIL ns_stall: got s=%0d pc=%h expected s=3 pc=700", stall_cnt0, out_pc0); end
    out_ready0 = 1'b1;
    step();
    drive0(1'b0, 32'h0);
    checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h704) begin errors++; $display("FAIL ns_b2b: got v=%b pc=%h expected v=1 pc=704", out_valid0, out_pc0); end
    step();
    checks++; if (out_valid0 !== 1'b0 || out_inst0 !== NOP) begin errors++; $display("FAIL ns_drain: got v=%b inst=%h expected v=0 inst=%h", out_valid0, out_inst0, NOP); end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
    in_valid0 = 1'b0; in_pc0 = '0; in_inst0 = '0; out_ready0 = 1'b0; flush0 = 1'b0; cnt_clear0 = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_idle_counters();
    test_async_reset();
    test_saturate();
    test_noskid();
    step(2);
    checks++; if (sb_q.size() != 0 || sb_q0.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d/%0d entries expected 0/0", sb_q.size(), sb_q0.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register carrying a PC/instruction pair between fetch and decode, or between any two stages.
- Uses a valid/ready handshake, so a stall holds the stage's contents instead of destroying them.
- A flush inserts a NOP bubble.
- An optional skid buffer makes in_ready purely registered.
- Saturating stall/flush/bubble counters give pipeline performance visibility.

Parameters:
- PC_W, 32, PC field width.
- INST_W, 32, instruction field width.
- NOP_INST, 32'h00000013, instruction value driven while the stage is empty (addi x0,x0,0).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream has a PC/instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  PC_W  upstream PC.
- in_inst  in  INST_W  upstream instruction.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts; low = stall.
- out_pc  out  PC_W  held PC.
- out_inst  out  INST_W  held instruction.
- flush  in  1  branch-taken / kill; discards all held and incoming entries.
- cnt_clear  in  1  synchronous clear of all counters.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.
- flush_cnt  out  CNT_W  cycles with flush high.
- bubble_cnt  out  CNT_W  cycles with out_valid low and flush low.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While reset_n is low: out_valid=0, out_pc=0, out_inst=NOP_INST, skid empty, all counters=0.
  - in_ready=1 after reset (SKID=1); for SKID=0 it follows the combinational rule below.
  - Reset mid-operation drops all entries immediately with no partial update.
- Transfers:
  - Accept = in_valid & in_ready.
  - Send = out_valid & out_ready.
  - All data state updates on posedge clk.
- Latency: one cycle from accept to out_valid when the stage is empty. Throughput is one entry per cycle when out_ready is held high.
- Main register update (flush low):
  - If main is empty or Send occurs: main loads the skid entry if the skid is valid; otherwise it loads the input if Accept; otherwise it becomes empty.
  - Otherwise main holds its value; stall never alters the payload.
- Skid (SKID=1):
  - Accept while main is full and Send does not occur writes the input into the skid.
  - The skid drains into main on the next main load.
  - in_ready = !skid_valid, registered.
  - Input and skid are never both pending into main, so no entry is ever lost.
- SKID=0: in_ready = !out_valid | out_ready (combinational); no skid register.
- Empty stage: out_pc=0 and out_inst=NOP_INST whenever out_valid=0. Downstream sees a clean bubble regardless of ready.
- Ordering: entries leave in acceptance order; no duplication, no drop, except by flush.
- Flush (synchronous, highest priority):
  - Next cycle: out_valid=0, skid empty, out_pc=0, out_inst=NOP_INST.
  - Any Accept in the same cycle is discarded, and in_ready may remain 1.
  - A Send in the flush cycle still completes (downstream has sampled it).
- Simultaneous flush + stall: flush wins; the held entry is discarded.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clear zeroes all three next cycle and takes priority over increment that cycle.
  - stall_cnt and flush_cnt may increment in the same cycle.
  - bubble_cnt excludes flush cycles.
- No X on any output after reset release, provided inputs are known.

Test Plan:
- Reset then stream pc=0x100,0x104,0x108 with out_ready=1 -> outputs appear one cycle after each accept in order; out_valid continuous; stall_cnt=0.
- Stream 0x200, 0x204, then out_ready=0 for 3 cycles -> out_pc holds 0x200; in_ready drops after the skid takes 0x204 (SKID=1); stall_cnt=3; on release 0x200 then 0x204 emerge in order, none lost.
- Stage full with 0x300 and stalled, skid holding 0x304, assert flush one cycle together with in_valid (0x308) -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0; 0x308 discarded; flush_cnt=1.
- Idle 5 cycles with in_valid=0 -> bubble_cnt=5; out_inst=NOP_INST throughout; then cnt_clear -> all counters 0 next cycle.
- Assert reset_n=0 asynchronously mid-stall with the stage full -> out_valid falls without a clock edge; counters 0; a fresh stream after release works normally.
- CNT_W=4, hold a stall for 20 cycles -> stall_cnt saturates at 15.
- SKID=0 build, repeat the stall scenario -> in_ready follows !out_valid|out_ready combinationally; no entry lost.
